// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared widths and clear-mode decode for the nibble register loader
//
// Purpose : common default widths for the loader and the pin-level clear-mode
//           enum used by glue logic to build a per-channel clear mask.
// Contents: LOADER_DIN_W, LOADER_REG_W, clr_mode_e, clr_mode_to_mask()
package loader_pkg;

  localparam int LOADER_DIN_W = 4;
  localparam int LOADER_REG_W = 32;

  // Pin-level clear encodings decoded by top-level glue into clr_mask.
  typedef enum logic [1:0] {
    CLR_NONE = 2'd0,
    CLR_CH0  = 2'd1,
    CLR_CH1  = 2'd2,
    CLR_ALL  = 2'd3
  } clr_mode_e;

  // Returns a 32-bit mask; callers slice off the low NUM_CH bits.
  function automatic logic [31:0] clr_mode_to_mask(clr_mode_e mode);
    logic [31:0] mask;
    mask = '0;
    case (mode)
      CLR_CH0: mask = 32'h0000_0001;
      CLR_CH1: mask = 32'h0000_0002;
      CLR_ALL: mask = 32'hFFFF_FFFF;
      default: mask = '0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/loader_channel.sv
// rtl/loader_channel.sv - one channel: staging shift register, fill count, flags, shadow register
//
// Purpose : accumulates DIN_W-bit beats MSB-first into a REG_W-bit staging
//           register and moves it to the shadow register on commit when full.
// Ports   : clk_i, rst_i      clock, synchronous active-high reset
//           din_i             data beat
//           wr_i              beat addressed to this channel
//           commit_i          global commit strobe
//           clr_i             clear staging, count and ovf (highest priority)
//           shadow_o          committed register value
//           full_o            staging holds BEATS beats (combinational)
//           ovf_o             sticky dropped-beat flag
//           loaded_o          one-cycle pulse after a commit of this channel
module loader_channel
  import loader_pkg::*;
#(
  parameter int REG_W = LOADER_REG_W,
  parameter int DIN_W = LOADER_DIN_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DIN_W-1:0] din_i,
  input  logic             wr_i,
  input  logic             commit_i,
  input  logic             clr_i,
  output logic [REG_W-1:0] shadow_o,
  output logic             full_o,
  output logic             ovf_o,
  output logic             loaded_o
);

  localparam int BEATS = REG_W / DIN_W;
  localparam int CNT_W = $clog2(BEATS + 1);

  logic [REG_W-1:0] stage_q,  stage_d;
  logic [REG_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             ovf_q,    ovf_d;
  logic             loaded_q, loaded_d;

  logic             full_w;
  logic             take_commit;
  logic [REG_W-1:0] stage_shift;

  assign full_w      = (cnt_q == CNT_W'(BEATS));
  assign take_commit = commit_i && full_w;
  // Written as a shift/or so the REG_W == DIN_W corner needs no special case.
  assign stage_shift = (stage_q << DIN_W) | REG_W'(din_i);

  always_comb begin
    stage_d  = stage_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    loaded_d = 1'b0;
    if (clr_i) begin
      // Clear wins over both a write and a commit to this channel.
      stage_d = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      if (take_commit) begin
        shadow_d = stage_q;
        cnt_d    = '0;
        loaded_d = 1'b1;
      end
      if (wr_i) begin
        if (full_w && !commit_i) begin
          ovf_d = 1'b1;
        end else begin
          // A beat landing on a committing channel starts the next fill.
          stage_d = stage_shift;
          cnt_d   = take_commit ? CNT_W'(1) : cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_q  <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      stage_q  <= stage_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      loaded_q <= loaded_d;
    end
  end

  assign shadow_o = shadow_q;
  assign full_o   = full_w;
  assign ovf_o    = ovf_q;
  assign loaded_o = loaded_q;

endmodule

// File: rtl/nibble_reg_loader.sv
// rtl/nibble_reg_loader.sv - multi-channel register loader fed from a narrow beat bus
//
// Purpose : decodes sel into per-channel write strobes and instantiates
//           NUM_CH loader_channel blocks sharing one commit strobe.
// Ports   : clk, rst          clock, synchronous active-high reset
//           din, sel          data beat and target channel
//           din_valid         beat strobe
//           commit            move every full staging register to regs_out
//           clr_mask          per-channel clear of staging, count and ovf
//           regs_out          shadow registers, channel c at [c*REG_W +: REG_W]
//           full, ovf, loaded per-channel status
module nibble_reg_loader
  import loader_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int REG_W  = LOADER_REG_W,
  parameter int DIN_W  = LOADER_DIN_W,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DIN_W-1:0]        din,
  input  logic [CH_W-1:0]         sel,
  input  logic                    din_valid,
  input  logic                    commit,
  input  logic [NUM_CH-1:0]       clr_mask,
  output logic [NUM_CH*REG_W-1:0] regs_out,
  output logic [NUM_CH-1:0]       full,
  output logic [NUM_CH-1:0]       ovf,
  output logic [NUM_CH-1:0]       loaded
);

  // sel values at or above NUM_CH match no channel, so those beats vanish.
  logic [NUM_CH-1:0] wr_w;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign wr_w[c] = din_valid && (sel == CH_W'(c));

    loader_channel #(
      .REG_W (REG_W),
      .DIN_W (DIN_W)
    ) u_channel (
      .clk_i    (clk),
      .rst_i    (rst),
      .din_i    (din),
      .wr_i     (wr_w[c]),
      .commit_i (commit),
      .clr_i    (clr_mask[c]),
      .shadow_o (regs_out[c*REG_W +: REG_W]),
      .full_o   (full[c]),
      .ovf_o    (ovf[c]),
      .loaded_o (loaded[c])
    );
  end

endmodule

// File: doc/nibble_reg_loader.md
# nibble_reg_loader

Parametrised multi-channel register loader that fills NUM_CH independent REG_W-bit registers, such as weight and data banks, from a narrow DIN_W-bit input bus. It sits between the tile's dedicated input pins and the compute datapath. Each channel has a staging shift register, a fill counter and full/overflow flags. A commit strobe atomically transfers every full staging register into its output (shadow) register, so the datapath never sees a partially loaded word.

## Interface
Parameters:
- NUM_CH, 2, number of channels (≥1)
- REG_W, 32, bits per channel register; must be a multiple of DIN_W
- DIN_W, 4, input bus width per beat
- CH_W, $clog2(NUM_CH) with a minimum of 1, channel-select width (localparam)

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  reset; synchronous, active-high
- din  in  DIN_W  data beat
- sel  in  CH_W  target channel for din
- din_valid  in  1  beat strobe
- commit  in  1  transfer all full staging registers to outputs
- clr_mask  in  NUM_CH  per-channel clear of staging, count and ovf
- regs_out  out  NUM_CH*REG_W  shadow registers; channel c at bits [c*REG_W +: REG_W]
- full  out  NUM_CH  staging register holds REG_W/DIN_W beats
- ovf  out  NUM_CH  sticky flag: a beat was dropped on a full channel
- loaded  out  NUM_CH  one-cycle pulse marking channels updated by commit

## Operation
- BEATS = REG_W/DIN_W. Count width is $clog2(BEATS+1).
- Write: when din_valid is high and sel < NUM_CH, staging[sel] <= {staging[sel][REG_W-DIN_W-1:0], din} and count is incremented. Data is loaded MSB-first, so the first beat ends in the top nibble.
- full[c] = (count[c] == BEATS). This output is combinational from the count register.
- A write to a full channel that is not committing that cycle is dropped, and ovf[c] is set. Staging and count are unchanged.
- A write with sel ≥ NUM_CH is dropped silently, with no flag.
- Commit: for every channel with full[c] high, regs_out[c] <= staging[c], count[c] <= 0 and loaded[c] <= 1. Channels that are not full are untouched, and their loaded bit is 0.
- Commit and write to the same full channel in the same cycle: regs_out takes the old staging contents. The beat starts a new fill: staging is shifted with din and count becomes 1. ovf is not set.
- clr_mask[c]: staging[c] <= 0, count[c] <= 0, ovf[c] <= 0. regs_out[c] is not affected.
- clr_mask[c] takes priority over a write to c and over a commit of c in the same cycle. That channel does not commit, and its loaded bit stays 0.
- rst: staging, count, regs_out, ovf and loaded are all cleared to 0, which also drives full to 0. rst overrides every other input. A reset in the middle of a fill discards the partial data.

## Timing
- Each beat is accepted on the edge where din_valid is sampled. A channel can take a beat every cycle, so a full load takes BEATS cycles.
- full rises in the cycle after the last beat's edge.
- regs_out and loaded update on the commit edge and are visible the next cycle. loaded lasts exactly one cycle.
- There is no backpressure. The upstream side must either watch full or accept ovf.
- The earliest usable load sequence is: BEATS beats, then commit one or more cycles later. The commit may be in the cycle immediately after the last beat.

## Structure
- Shared package `loader_pkg` holds the default widths (DIN_W, default REG_W) and a `clr_mode_e` enum. The enum is used by top-level glue to decode pin-level clear modes (none, ch0, ch1, all) into clr_mask.
- One natural sub-module, `loader_channel`, contains one channel's staging register, count, full, ovf and shadow register. The top generates NUM_CH instances and does the sel decode.
- Expected RTL size is about 150–250 lines in total.

## Test plan
- Basic load: defaults, 8 beats 0x1..0x8 to ch0, then commit. Required: full[0] = 1 after the 8th beat; the next cycle after commit has regs_out[31:0] = 0x12345678, loaded = 2'b01 for one cycle, and full[0] = 0.
- Overflow: 9 beats to ch1 with no commit. Required: ovf[1] = 1, staging keeps the first 8 beats, and a later commit gives those 8 beats. Then clr_mask = 2'b10 gives ovf[1] = 0 and full[1] = 0.
- Simultaneous commit and write: ch0 full with 0xAAAAAAAA, commit plus beat 0x5 in the same cycle. Required: regs_out[31:0] = 0xAAAAAAAA, count[0] = 1, ovf[0] = 0. Seven more beats of 0x0 followed by a commit gives 0x50000000.
- Partial channel and commit: ch0 full, ch1 holding 3 beats, then commit. Required: only ch0 updates, loaded = 2'b01, and ch1 keeps count 3 and its staging contents.
- Clear priority: clr_mask = 2'b01 together with commit while ch0 is full. Required: regs_out[0] is unchanged, loaded[0] = 0, and full[0] = 0.
- Reset mid-fill: 4 beats to ch0, then rst for 1 cycle. Required: all outputs are 0, and a fresh 8-beat load plus commit yields exactly the new data.
